uart_hex_loader: RTL and testbench

Boot-time loader front end: 8N1 UART receiver with input FIFO, UART transmitter, hex-text program loader writing bytes sequentially into RAM, and a 2-digit multiplexed 7-segment driver. After reset, the loader consumes ASCII hex from the UART until EOT, then asserts done and releases the RAM port. The display shows the last loaded byte before done and disp_val after done.

---
 rtl/uart_hex_loader.sv | 318 +++++++++++++++++++++++++++++++
 tb/tb_uart_hex_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_hex_loader.sv
// Boot-time loader front end: 8N1 UART RX with input FIFO, UART TX, ASCII-hex
// program loader writing sequential RAM bytes, and a 2-digit 7-segment driver.
module uart_hex_loader #(
    parameter int CLK_FREQ    = 12_000_000,
    parameter int BAUD        = 9_600,
    parameter int FIFO_DEPTH  = 16,
    parameter int ADDR_W      = 16,
    parameter int REFRESH_CYC = 12_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              tx,
    input  logic              putc_push,
    input  logic [7:0]        putc_char,
    output logic              putc_ready,
    output logic              inbuf_empty,
    output logic              inbuf_full,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              ram_we,
    output logic              done,
    output logic [7:0]        byte_val,
    output logic              byte_valid,
    input  logic [7:0]        disp_val,
    output logic [7:0]        hex_pins
);
    localparam int BIT_CYC = CLK_FREQ / BAUD;
    localparam int CW      = $clog2(BIT_CYC + 1);
    localparam int PW      = $clog2(FIFO_DEPTH);
    localparam int RW      = $clog2(REFRESH_CYC + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYC / 2 - 1);
    localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_CYC - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic       {TX_IDLE, TX_BUSY} tx_state_e;
    typedef enum logic [1:0] {L_HI, L_LO, L_DONE} ld_state_e;

    // receiver
    logic            rx_s1_q, rx_s2_q, rx_s3_q;
    rx_state_e       rx_st_q, rx_st_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_sh_q, rx_sh_d;
    logic            rx_push_q, rx_push_d;
    // fifo
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PW:0]     wr_q, rd_q;
    logic            do_push, do_pop;
    logic [7:0]      head;
    // transmitter
    tx_state_e       tx_st_q, tx_st_d;
    logic            tx_q, tx_d;
    logic [7:0]      tx_sh_q, tx_sh_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [3:0]      tx_bit_q, tx_bit_d;
    // loader
    ld_state_e       ld_q, ld_d;
    logic [3:0]      nib_q, nib_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic            we_q, we_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [7:0]      bval_q, bval_d;
    logic            bvalid_q, bvalid_d;
    logic            ld_pop;
    logic [4:0]      hd;
    logic            is_ws;
    // display
    logic [RW-1:0]   ref_q;
    logic            dig_q;
    logic [7:0]      hex_q;
    logic [7:0]      shown;

    function automatic logic [4:0] hex_dec(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39)
            return {1'b1, c[3:0]};
        else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
            return {1'b1, c[3:0] + 4'd9};
        else
            return 5'b0;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // ---------------- RX ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_s3_q   <= 1'b1;
            rx_st_q   <= RX_IDLE;
            rx_cnt_q  <= '0;
            rx_bit_q  <= '0;
            rx_sh_q   <= '0;
            rx_push_q <= 1'b0;
        end else begin
            rx_s1_q   <= rx;
            rx_s2_q   <= rx_s1_q;
            rx_s3_q   <= rx_s2_q;
            rx_st_q   <= rx_st_d;
            rx_cnt_q  <= rx_cnt_d;
            rx_bit_q  <= rx_bit_d;
            rx_sh_q   <= rx_sh_d;
            rx_push_q <= rx_push_d;
        end
    end

    always_comb begin
        rx_st_d   = rx_st_q;
        rx_cnt_d  = rx_cnt_q + 1'b1;
        rx_bit_d  = rx_bit_q;
        rx_sh_d   = rx_sh_q;
        rx_push_d = 1'b0;
        case (rx_st_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_s3_q && !rx_s2_q) rx_st_d = RX_START;
            end
            RX_START: if (rx_cnt_q == HALF_LAST) begin
                // a start bit that is high again mid-bit was only a glitch
                rx_cnt_d = '0;
                rx_bit_d = '0;
                rx_st_d  = rx_s2_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt_q == BIT_LAST) begin
                rx_cnt_d = '0;
                rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                rx_bit_d = rx_bit_q + 1'b1;
                if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
            end
            RX_STOP: if (rx_cnt_q == BIT_LAST) begin
                rx_cnt_d  = '0;
                rx_st_d   = RX_IDLE;
                rx_push_d = rx_s2_q;
            end
            default: rx_st_d = RX_IDLE;
        endcase
    end

    // ---------------- FIFO ----------------
    assign inbuf_empty = (wr_q == rd_q);
    assign inbuf_full  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign do_pop      = ld_pop && !inbuf_empty;
    assign do_push     = rx_push_q && (!inbuf_full || do_pop);
    assign head        = mem_q[rd_q[PW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && do_push) mem_q[wr_q[PW-1:0]] <= rx_sh_q;
    end

    // ---------------- TX ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_st_q  <= TX_IDLE;
            tx_q     <= 1'b1;
            tx_sh_q  <= '0;
            tx_cnt_q <= '0;
            tx_bit_q <= '0;
        end else begin
            tx_st_q  <= tx_st_d;
            tx_q     <= tx_d;
            tx_sh_q  <= tx_sh_d;
            tx_cnt_q <= tx_cnt_d;
            tx_bit_q <= tx_bit_d;
        end
    end

    always_comb begin
        tx_st_d  = tx_st_q;
        tx_d     = tx_q;
        tx_sh_d  = tx_sh_q;
        tx_cnt_d = tx_cnt_q + 1'b1;
        tx_bit_d = tx_bit_q;
        case (tx_st_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                if (putc_push) begin
                    tx_st_d  = TX_BUSY;
                    tx_d     = 1'b0;
                    tx_sh_d  = putc_char;
                    tx_bit_d = '0;
                end
            end
            TX_BUSY: if (tx_cnt_q == BIT_LAST) begin
                // ones shift in behind the data, so bit 9 on the line is the stop bit
                tx_cnt_d = '0;
                if (tx_bit_q == 4'd9) begin
                    tx_st_d = TX_IDLE;
                    tx_d    = 1'b1;
                end else begin
                    tx_d     = tx_sh_q[0];
                    tx_sh_d  = {1'b1, tx_sh_q[7:1]};
                    tx_bit_d = tx_bit_q + 1'b1;
                end
            end
            default: tx_st_d = TX_IDLE;
        endcase
    end

    assign tx         = tx_q;
    assign putc_ready = (tx_st_q == TX_IDLE);

    // ---------------- loader ----------------
    assign hd    = hex_dec(head);
    assign is_ws = (head == 8'h20) || (head == 8'h09) || (head == 8'h0D) || (head == 8'h0A);

    always_ff @(posedge clk) begin
        if (!rst) begin
            ld_q     <= L_HI;
            nib_q    <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            bval_q   <= '0;
            bvalid_q <= 1'b1;
        end else begin
            ld_q     <= ld_d;
            nib_q    <= nib_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            bval_q   <= bval_d;
            bvalid_q <= bvalid_d;
        end
    end

    always_comb begin
        ld_d     = ld_q;
        nib_d    = nib_q;
        we_d     = 1'b0;
        wdata_d  = wdata_q;
        bval_d   = bval_q;
        bvalid_d = bvalid_q;
        ld_pop   = 1'b0;
        // the address presented with a write advances once that write is done
        addr_d   = we_q ? addr_q + 1'b1 : addr_q;
        if (ld_q != L_DONE && !inbuf_empty) begin
            ld_pop = 1'b1;
            if (head == 8'h04) begin
                ld_d = L_DONE;
            end else if (hd[4]) begin
                if (ld_q == L_HI) begin
                    nib_d = hd[3:0];
                    ld_d  = L_LO;
                end else begin
                    we_d     = 1'b1;
                    wdata_d  = {nib_q, hd[3:0]};
                    bval_d   = {nib_q, hd[3:0]};
                    bvalid_d = 1'b1;
                    ld_d     = L_HI;
                end
            end else if (!(is_ws && ld_q == L_HI)) begin
                bval_d   = head;
                bvalid_d = 1'b0;
                ld_d     = L_HI;
            end
        end
    end

    assign ram_addr   = addr_q;
    assign ram_we     = we_q;
    assign ram_wdata  = wdata_q;
    assign done       = (ld_q == L_DONE);
    assign byte_val   = bval_q;
    assign byte_valid = bvalid_q;

    // ---------------- display ----------------
    assign shown = done ? disp_val : bval_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ref_q <= '0;
            dig_q <= 1'b0;
            hex_q <= 8'h7F;
        end else begin
            if (ref_q == REF_LAST) begin
                ref_q <= '0;
                dig_q <= ~dig_q;
            end else begin
                ref_q <= ref_q + 1'b1;
            end
            hex_q <= {dig_q, seg7(dig_q ? shown[7:4] : shown[3:0])};
        end
    end

    assign hex_pins = hex_q;

endmodule

// File: tb/tb_uart_hex_loader.sv
// Directed + randomized bench for uart_hex_loader; a character-level loader
// model predicts RAM writes, byte_val/byte_valid, done and the next address.
module tb_uart_hex_loader;
    localparam int CLK_FREQ = 160;
    localparam int BAUD     = 10;
    localparam int B        = CLK_FREQ / BAUD;
    localparam int DEPTH    = 16;
    localparam int AW       = 16;
    localparam int REF      = 50;

    logic          clk = 1'b0, rst = 1'b0, rx = 1'b1, putc_push = 1'b0;
    logic [7:0]    putc_char = 8'h00, disp_val = 8'h00;
    logic          tx, putc_ready, inbuf_empty, inbuf_full, ram_we, done, byte_valid;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata, byte_val, hex_pins;

    uart_hex_loader #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH),
                      .ADDR_W(AW), .REFRESH_CYC(REF)) dut (
        .clk(clk), .rst(rst), .rx(rx), .tx(tx), .putc_push(putc_push),
        .putc_char(putc_char), .putc_ready(putc_ready), .inbuf_empty(inbuf_empty),
        .inbuf_full(inbuf_full), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .done(done), .byte_val(byte_val), .byte_valid(byte_valid),
        .disp_val(disp_val), .hex_pins(hex_pins));

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    logic [23:0] wq[$], ewq[$];

    // model state
    int         m_addr;
    bit         m_have, m_bvalid, m_done;
    logic [3:0] m_hi;
    logic [7:0] m_bval;

    logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [7:0] WS_TAB [4]    = '{8'h20, 8'h09, 8'h0D, 8'h0A};
    logic [7:0] OTHER_TAB [6] = '{8'h67, 8'h5A, 8'h21, 8'h23, 8'h2E, 8'h78};

    always @(negedge clk) if (rst && ram_we) wq.push_back({ram_addr, ram_wdata});

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int hexv(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
        if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
        if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
        return -1;
    endfunction

    task automatic model_char(input logic [7:0] c);
        int v;
        v = hexv(c);
        if (m_done) return;
        if (c == 8'h04) begin
            m_done = 1; m_have = 0;
        end else if (v >= 0) begin
            if (!m_have) begin
                m_hi = v[3:0]; m_have = 1;
            end else begin
                ewq.push_back({m_addr[15:0], m_hi, v[3:0]});
                m_bval = {m_hi, v[3:0]}; m_bvalid = 1; m_have = 0;
                m_addr = (m_addr + 1) % 65536;
            end
        end else if (!((c == 8'h20 || c == 8'h09 || c == 8'h0D || c == 8'h0A) && !m_have)) begin
            m_bval = c; m_bvalid = 0; m_have = 0;
        end
    endtask

    task automatic send(input logic [7:0] c, input bit stop);
        rx = 1'b0; cyc(B);
        for (int i = 0; i < 8; i++) begin rx = c[i]; cyc(B); end
        rx = stop; cyc(B);
        rx = 1'b1; cyc(2);
    endtask

    task automatic send_ld(input logic [7:0] c);
        model_char(c);
        send(c, 1'b1);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_ld(s[i]);
        cyc(4);
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".nwr"}, wq.size(), ewq.size());
        for (int i = 0; i < ewq.size() && i < wq.size(); i++) chk({tag, ".wr"}, wq[i], ewq[i]);
        chk({tag, ".bval"}, byte_val, m_bval);
        chk({tag, ".bvalid"}, byte_valid, m_bvalid);
        chk({tag, ".done"}, done, m_done);
        chk({tag, ".addr"}, ram_addr, m_addr);
        chk({tag, ".we_idle"}, ram_we, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0; rx = 1'b1; putc_push = 1'b0;
        cyc(3);
        chk({tag, ".tx"}, tx, 1'b1);
        chk({tag, ".ready"}, putc_ready, 1'b1);
        chk({tag, ".empty"}, inbuf_empty, 1'b1);
        chk({tag, ".full"}, inbuf_full, 1'b0);
        chk({tag, ".addr"}, ram_addr, 0);
        chk({tag, ".we"}, ram_we, 1'b0);
        chk({tag, ".wdata"}, ram_wdata, 8'h00);
        chk({tag, ".done"}, done, 1'b0);
        chk({tag, ".bval"}, byte_val, 8'h00);
        chk({tag, ".bvalid"}, byte_valid, 1'b1);
        chk({tag, ".hex"}, hex_pins, 8'h7F);
        wq.delete(); ewq.delete();
        m_addr = 0; m_have = 0; m_bvalid = 1; m_done = 0; m_hi = 0; m_bval = 0;
        rst = 1'b1;
        cyc(2);
    endtask

    task automatic disp_scan(input string tag, input logic [7:0] val, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk(tag, hex_pins[6:0], SEG[hex_pins[7] ? val[7:4] : val[3:0]]);
        end
        cyc(0);
    endtask

    initial begin
        logic [7:0] c;
        int v, t, w;
        logic prev;

        do_reset("rst0");

        // error recovery
        send_str("G");
        check_state("G");
        chk("G.bval_lit", byte_val, 8'h47);
        send_str("1 ");
        check_state("one_sp");
        chk("sp.bval_lit", byte_val, 8'h20);
        send_str("12");
        check_state("12");
        chk("12.addr_lit", ram_addr, 1);

        // single byte
        do_reset("rst1");
        send_str("3A");
        check_state("3A");
        chk("3A.bval_lit", byte_val, 8'h3A);
        disp_scan("disp_pre", 8'h3A, 2 * REF + 4);

        // randomized text
        for (int k = 0; k < 24; k++) begin
            v = $urandom_range(0, 9);
            if (v <= 5 || v == 9) begin
                v = $urandom_range(0, 15);
                c = (v < 10) ? 8'(48 + v) : 8'(($urandom_range(0, 1) ? 65 : 97) + v - 10);
            end else if (v <= 7) begin
                c = WS_TAB[$urandom_range(0, 3)];
            end else begin
                c = OTHER_TAB[$urandom_range(0, 5)];
            end
            send_ld(c);
        end
        cyc(4);
        check_state("rand");

        // multi-byte with whitespace, then EOT
        do_reset("rst2");
        send_str("de ad\r\nbe ef");
        send_ld(8'h04);
        cyc(4);
        check_state("eot");
        chk("eot.done", done, 1'b1);
        send_str("11");
        check_state("post_done");
        chk("post_done.nonempty", inbuf_empty, 1'b0);

        // receiver rejects, FIFO limits
        do_reset("rst3");
        send_ld(8'h04);
        cyc(4);
        chk("eot2.done", done, 1'b1);
        chk("eot2.empty", inbuf_empty, 1'b1);
        rx = 1'b0; cyc(B / 2 - 3); rx = 1'b1; cyc(2 * B);
        chk("glitch.empty", inbuf_empty, 1'b1);
        send(8'h55, 1'b0); rx = 1'b1; cyc(B);
        chk("framing.empty", inbuf_empty, 1'b1);
        for (int k = 1; k <= 17; k++) begin
            send(8'(8'h40 + k), 1'b1);
            if (k == 1)  chk("fifo1.empty", inbuf_empty, 1'b0);
            if (k == 15) chk("fifo15.full", inbuf_full, 1'b0);
            if (k >= 16) chk("fifo_full", inbuf_full, 1'b1);
        end
        chk("fifo17.empty", inbuf_empty, 1'b0);

        // transmitter frame, push while busy ignored
        @(posedge clk); #1;
        putc_char = 8'h55; putc_push = 1'b1;
        cyc(1);
        putc_push = 1'b0;
        for (int i = 0; i < 10; i++) begin
            w = (i == 0) ? B / 2 : ((i == 5) ? B - 1 : B);
            repeat (w) @(negedge clk);
            chk("tx.bit", tx, (i == 0) ? 1'b0 : ((i == 9) ? 1'b1 : ((8'h55 >> (i - 1)) & 1)));
            chk("tx.busy", putc_ready, 1'b0);
            if (i == 4) begin
                putc_char = 8'h00; putc_push = 1'b1;
                @(negedge clk);
                putc_push = 1'b0;
            end
        end
        repeat (B / 2) @(negedge clk);
        chk("tx.ready_late", putc_ready, 1'b0);
        @(negedge clk);
        chk("tx.ready", putc_ready, 1'b1);
        chk("tx.idle", tx, 1'b1);
        repeat (B) @(negedge clk);
        chk("tx.no_second", tx, 1'b1);

        // display after done
        disp_val = 8'hB7;
        cyc(3);
        @(negedge clk);
        prev = hex_pins[7];
        for (int k = 0; k < 4; k++) begin
            t = 0;
            do begin @(negedge clk); t++; end while (hex_pins[7] === prev && t < 2 * REF);
            if (k > 0) chk("disp.period", t, REF);
            prev = hex_pins[7];
            chk("disp.seg", hex_pins[6:0], prev ? 7'h03 : 7'h78);
        end
        disp_scan("disp_done", 8'hB7, REF + 4);

        // reset mid-operation: tx frame and rx frame in flight, FIFO full, done set
        @(posedge clk); #1;
        putc_char = 8'hA5; putc_push = 1'b1;
        cyc(1);
        putc_push = 1'b0;
        rx = 1'b0;
        cyc(2 * B);
        do_reset("rst_mid");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
